// File: rtl/macc_seq_pkg.sv
// macc_seq_pkg: shared types and default sizing for the multiply-add sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package macc_seq_pkg;

   localparam int DEF_DATA_W  = 16;
   localparam int DEF_ACC_W   = 48;
   localparam int DEF_LEN_W   = 8;
   localparam int DEF_MAC_LAT = 3;

   // Width needed to hold a latency countdown value of 0..lat.
   function automatic int lat_cnt_w(input int lat);
      return (lat < 1) ? 1 : $clog2(lat + 1);
   endfunction

   localparam int LAT_CNT_W = lat_cnt_w(DEF_MAC_LAT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_WAIT,
      S_RESULT
   } state_t;

endpackage

// File: rtl/macc_sequencer_if.sv
// macc_sequencer_if: job control, operand stream, DSP core and result stream signals.
// Latency: n/a (wiring only).
// Backpressure: op_valid/op_ready on operands, res_valid/res_ready on the result.
// Ports: slave = sequencer side, master = environment (operand source, core, consumer).
interface macc_sequencer_if
   import macc_seq_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ACC_W  = DEF_ACC_W,
   parameter int LEN_W  = DEF_LEN_W
);
   // job control
   logic              start;
   logic [LEN_W-1:0]  len;
   logic              abort;
   logic              busy;
   // operand stream
   logic              op_valid;
   logic              op_ready;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   // multiply-add core
   logic [DATA_W-1:0] mac_a;
   logic [DATA_W-1:0] mac_b;
   logic [ACC_W-1:0]  mac_c;
   logic              mac_issue;
   logic              mac_sclr;
   logic [ACC_W-1:0]  mac_p;
   // result stream
   logic              res_valid;
   logic              res_ready;
   logic [ACC_W-1:0]  res_data;
   logic              done;

   modport slave (
      input  start, len, abort, op_valid, op_a, op_b, mac_p, res_ready,
      output busy, op_ready, mac_a, mac_b, mac_c, mac_issue, mac_sclr,
             res_valid, res_data, done
   );

   modport master (
      output start, len, abort, op_valid, op_a, op_b, mac_p, res_ready,
      input  busy, op_ready, mac_a, mac_b, mac_c, mac_issue, mac_sclr,
             res_valid, res_data, done
   );

endinterface

// File: rtl/macc_sequencer.sv
// macc_sequencer: issues one multiply-add per operand pair, chaining the partial sum via mac_c.
// Latency: MAC_LAT+2 cycles per pair with operands available; result valid 1+N*(MAC_LAT+2) after start.
// Backpressure: stalls in FETCH on op_valid low; holds result until res_ready; abort wins over all.
// Ports: clk, reset (async active-high), bus (slave modport of macc_sequencer_if).
module macc_sequencer
   import macc_seq_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ACC_W   = DEF_ACC_W,
   parameter int LEN_W   = DEF_LEN_W,
   parameter int MAC_LAT = DEF_MAC_LAT
) (
   input  logic            clk,
   input  logic            reset,
   macc_sequencer_if.slave bus
);

   localparam int LCW = lat_cnt_w(MAC_LAT);

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic              first_q, first_d;
   logic [LCW-1:0]    lat_q, lat_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [DATA_W-1:0] mac_a_q, mac_a_d;
   logic [DATA_W-1:0] mac_b_q, mac_b_d;
   logic [ACC_W-1:0]  mac_c_q, mac_c_d;
   logic              sclr_q, sclr_d;

   logic              op_ready_c;
   logic              done_c;
   logic [LEN_W-1:0]  cnt_inc;

   assign cnt_inc = cnt_q + LEN_W'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         first_q <= 1'b0;
         lat_q   <= '0;
         acc_q   <= '0;
         mac_a_q <= '0;
         mac_b_q <= '0;
         mac_c_q <= '0;
         sclr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         first_q <= first_d;
         lat_q   <= lat_d;
         acc_q   <= acc_d;
         mac_a_q <= mac_a_d;
         mac_b_q <= mac_b_d;
         mac_c_q <= mac_c_d;
         sclr_q  <= sclr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      first_d    = first_q;
      lat_d      = lat_q;
      acc_d      = acc_q;
      mac_a_d    = mac_a_q;
      mac_b_d    = mac_b_q;
      mac_c_d    = mac_c_q;
      sclr_d     = 1'b0;
      op_ready_c = 1'b0;
      done_c     = 1'b0;

      if (bus.abort) begin
         // Abort drops the job and anything still in the core pipeline.
         state_d = S_IDLE;
         sclr_d  = 1'b1;
         acc_d   = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  len_d   = bus.len;
                  cnt_d   = '0;
                  first_d = 1'b1;
                  // Cleared so an empty job reports 0, not the previous sum.
                  acc_d   = '0;
                  state_d = (bus.len == '0) ? S_RESULT : S_FETCH;
               end
            end
            S_FETCH: begin
               op_ready_c = 1'b1;
               if (bus.op_valid) begin
                  mac_a_d = bus.op_a;
                  mac_b_d = bus.op_b;
                  mac_c_d = first_q ? '0 : acc_q;
                  first_d = 1'b0;
                  state_d = S_ISSUE;
               end
            end
            S_ISSUE: begin
               lat_d   = LCW'(MAC_LAT - 1);
               state_d = S_WAIT;
            end
            S_WAIT: begin
               if (lat_q == '0) begin
                  // mac_p is valid in this last wait cycle only.
                  acc_d   = bus.mac_p;
                  cnt_d   = cnt_inc;
                  state_d = (cnt_inc == len_q) ? S_RESULT : S_FETCH;
               end else begin
                  lat_d = lat_q - LCW'(1);
               end
            end
            S_RESULT: begin
               if (bus.res_ready) begin
                  done_c  = 1'b1;
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign bus.busy      = (state_q != S_IDLE);
   assign bus.op_ready  = op_ready_c;
   assign bus.mac_a     = mac_a_q;
   assign bus.mac_b     = mac_b_q;
   assign bus.mac_c     = mac_c_q;
   assign bus.mac_issue = (state_q == S_ISSUE);
   assign bus.mac_sclr  = sclr_q;
   assign bus.res_valid = (state_q == S_RESULT);
   assign bus.res_data  = acc_q;
   assign bus.done      = done_c;

endmodule
